// File: rtl/axi4_flit_slave_bridge_if.sv
// ----------------------------------------------------------------------------
// axi4_flit_slave_bridge_if
//   Groups the flit link and the local AXI4 channels seen by the slave-side
//   flit bridge.
//   slave modport  : the bridge's view. It takes inbound flits, drives AW/W/AR,
//                    takes B/R, and drives outbound flits and err_cnt.
//   master modport : the opposite view, used by whatever surrounds the bridge.
//   Bit layouts (MSB..LSB):
//     aw_bits/ar_bits {user8,region4,qos4,prot3,cache4,lock1,burst2,size3,len8,addr32,id8}
//     w_bits          {user8,last1,strb8,data64}
//     b_bits          {user8,resp2,id8}
//     r_bits          {user8,last1,resp2,data64,id8}
// ----------------------------------------------------------------------------
interface axi4_flit_slave_bridge_if #(
  parameter int FLIT_WIDTH    = 92,
  parameter int ERR_CNT_WIDTH = 16
);
  logic                     flit_in_valid;
  logic [FLIT_WIDTH-1:0]    flit_in_data;
  logic                     flit_in_ready;
  logic                     aw_valid;
  logic                     aw_ready;
  logic [76:0]              aw_bits;
  logic                     w_valid;
  logic                     w_ready;
  logic [80:0]              w_bits;
  logic                     ar_valid;
  logic                     ar_ready;
  logic [76:0]              ar_bits;
  logic                     b_valid;
  logic                     b_ready;
  logic [17:0]              b_bits;
  logic                     r_valid;
  logic                     r_ready;
  logic [82:0]              r_bits;
  logic                     flit_out_valid;
  logic [FLIT_WIDTH-1:0]    flit_out_data;
  logic                     flit_out_ready;
  logic [ERR_CNT_WIDTH-1:0] err_cnt;

  modport slave (
    input  flit_in_valid, flit_in_data, aw_ready, w_ready, ar_ready,
           b_valid, b_bits, r_valid, r_bits, flit_out_ready,
    output flit_in_ready, aw_valid, aw_bits, w_valid, w_bits, ar_valid, ar_bits,
           b_ready, r_ready, flit_out_valid, flit_out_data, err_cnt
  );

  modport master (
    output flit_in_valid, flit_in_data, aw_ready, w_ready, ar_ready,
           b_valid, b_bits, r_valid, r_bits, flit_out_ready,
    input  flit_in_ready, aw_valid, aw_bits, w_valid, w_bits, ar_valid, ar_bits,
           b_ready, r_ready, flit_out_valid, flit_out_data, err_cnt
  );
endinterface

// File: rtl/axi4_flit_slave_bridge.sv
// ----------------------------------------------------------------------------
// axi4_flit_slave_bridge
//   Slave-side endpoint of the AXI4-over-NoC link.
//   Inbound : 92-bit flits are decoded by channel code [91:89] into 1-deep
//             AW / W / AR holding registers that drive the local slave.
//             Flits carrying B, R or undefined codes are accepted, dropped and
//             counted in a saturating err_cnt.
//   Outbound: B and R responses from the slave are arbitrated round-robin into
//             a single output flit register. An R burst locks the arbiter so
//             that B flits never interleave with it.
//   Ports:
//     clk    clock
//     rst    asynchronous active-high reset
//     bus_io slave modport of axi4_flit_slave_bridge_if (flit in/out, AW/W/AR
//            out, B/R in, err_cnt)
// ----------------------------------------------------------------------------
module axi4_flit_slave_bridge #(
  parameter int FLIT_WIDTH    = 92,
  parameter int ERR_CNT_WIDTH = 16
) (
  input logic                      clk,
  input logic                      rst,
  axi4_flit_slave_bridge_if.slave  bus_io
);

  localparam logic [2:0] CODE_AW = 3'b001;
  localparam logic [2:0] CODE_AR = 3'b010;
  localparam logic [2:0] CODE_W  = 3'b011;
  localparam logic [2:0] CODE_B  = 3'b101;
  localparam logic [2:0] CODE_R  = 3'b110;

  // Inbound state
  logic                     aw_valid_q, aw_valid_d;
  logic [76:0]              aw_bits_q,  aw_bits_d;
  logic                     w_valid_q,  w_valid_d;
  logic [80:0]              w_bits_q,   w_bits_d;
  logic                     ar_valid_q, ar_valid_d;
  logic [76:0]              ar_bits_q,  ar_bits_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q,  err_cnt_d;

  // Outbound state
  logic                     out_valid_q, out_valid_d;
  logic [FLIT_WIDTH-1:0]    out_data_q,  out_data_d;
  logic                     r_lock_q,    r_lock_d;
  logic                     last_r_q,    last_r_d;   // 1: R won the last grant

  logic [2:0] in_code_s;
  logic       in_ready_s;
  logic       in_fire_s;
  logic       in_bad_s;
  logic       out_loadable_s;
  logic       grant_b_s;
  logic       grant_r_s;
  logic       b_fire_s;
  logic       r_fire_s;
  logic       unused_payload_s;

  assign in_code_s = bus_io.flit_in_data[FLIT_WIDTH-1 -: 3];
  // Payload bits above the widest channel (W, 81 bits) carry nothing.
  assign unused_payload_s = ^bus_io.flit_in_data[FLIT_WIDTH-4:81];

  // Inbound ready: the target holding register is empty or drains this cycle.
  always_comb begin
    in_ready_s = 1'b1;
    in_bad_s   = 1'b0;
    case (in_code_s)
      CODE_AW: in_ready_s = !aw_valid_q || bus_io.aw_ready;
      CODE_W:  in_ready_s = !w_valid_q  || bus_io.w_ready;
      CODE_AR: in_ready_s = !ar_valid_q || bus_io.ar_ready;
      default: begin
        in_ready_s = 1'b1;
        in_bad_s   = 1'b1;
      end
    endcase
  end

  // Ready is held low while reset is asserted.
  assign bus_io.flit_in_ready = in_ready_s & ~rst;
  assign in_fire_s            = bus_io.flit_in_valid & bus_io.flit_in_ready;

  // Next state of the inbound holding registers and the drop counter.
  always_comb begin
    aw_valid_d = aw_valid_q;
    aw_bits_d  = aw_bits_q;
    w_valid_d  = w_valid_q;
    w_bits_d   = w_bits_q;
    ar_valid_d = ar_valid_q;
    ar_bits_d  = ar_bits_q;
    err_cnt_d  = err_cnt_q;

    if (in_fire_s && in_code_s == CODE_AW) begin
      aw_valid_d = 1'b1;
      aw_bits_d  = bus_io.flit_in_data[76:0];
    end else if (aw_valid_q && bus_io.aw_ready) begin
      aw_valid_d = 1'b0;
    end else begin
      aw_valid_d = aw_valid_q;
    end

    if (in_fire_s && in_code_s == CODE_W) begin
      w_valid_d = 1'b1;
      w_bits_d  = bus_io.flit_in_data[80:0];
    end else if (w_valid_q && bus_io.w_ready) begin
      w_valid_d = 1'b0;
    end else begin
      w_valid_d = w_valid_q;
    end

    if (in_fire_s && in_code_s == CODE_AR) begin
      ar_valid_d = 1'b1;
      ar_bits_d  = bus_io.flit_in_data[76:0];
    end else if (ar_valid_q && bus_io.ar_ready) begin
      ar_valid_d = 1'b0;
    end else begin
      ar_valid_d = ar_valid_q;
    end

    if (in_fire_s && in_bad_s && (err_cnt_q != {ERR_CNT_WIDTH{1'b1}})) begin
      err_cnt_d = err_cnt_q + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Arbiter: a locked R burst excludes B; otherwise alternate when both request.
  assign out_loadable_s = ~out_valid_q | bus_io.flit_out_ready;
  assign grant_b_s      = ~r_lock_q & bus_io.b_valid & (~bus_io.r_valid | last_r_q);
  assign grant_r_s      = bus_io.r_valid & (r_lock_q | ~bus_io.b_valid | ~last_r_q);
  assign bus_io.b_ready = grant_b_s & out_loadable_s & ~rst;
  assign bus_io.r_ready = grant_r_s & out_loadable_s & ~rst;
  assign b_fire_s       = bus_io.b_valid & bus_io.b_ready;
  assign r_fire_s       = bus_io.r_valid & bus_io.r_ready;

  // Next state of the outbound flit register, R-lock and round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    r_lock_d    = r_lock_q;
    last_r_d    = last_r_q;
    if (b_fire_s) begin
      out_valid_d = 1'b1;
      out_data_d  = {CODE_B, {(FLIT_WIDTH-3-18){1'b0}}, bus_io.b_bits};
      last_r_d    = 1'b0;
    end else if (r_fire_s) begin
      out_valid_d = 1'b1;
      out_data_d  = {CODE_R, {(FLIT_WIDTH-3-83){1'b0}}, bus_io.r_bits};
      last_r_d    = 1'b1;
      // r_bits[74] is the R last flag: hold the link until the burst ends.
      r_lock_d    = ~bus_io.r_bits[74];
    end else if (bus_io.flit_out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers; reset empties every holding register and selects B first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_valid_q  <= 1'b0;
      aw_bits_q   <= 77'd0;
      w_valid_q   <= 1'b0;
      w_bits_q    <= 81'd0;
      ar_valid_q  <= 1'b0;
      ar_bits_q   <= 77'd0;
      err_cnt_q   <= {ERR_CNT_WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {FLIT_WIDTH{1'b0}};
      r_lock_q    <= 1'b0;
      last_r_q    <= 1'b1;   // pretend R went last so B wins the first tie
    end else begin
      aw_valid_q  <= aw_valid_d;
      aw_bits_q   <= aw_bits_d;
      w_valid_q   <= w_valid_d;
      w_bits_q    <= w_bits_d;
      ar_valid_q  <= ar_valid_d;
      ar_bits_q   <= ar_bits_d;
      err_cnt_q   <= err_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      r_lock_q    <= r_lock_d;
      last_r_q    <= last_r_d;
    end
  end

  assign bus_io.aw_valid       = aw_valid_q;
  assign bus_io.aw_bits        = aw_bits_q;
  assign bus_io.w_valid        = w_valid_q;
  assign bus_io.w_bits         = w_bits_q;
  assign bus_io.ar_valid       = ar_valid_q;
  assign bus_io.ar_bits        = ar_bits_q;
  assign bus_io.flit_out_valid = out_valid_q;
  assign bus_io.flit_out_data  = out_data_q;
  assign bus_io.err_cnt        = err_cnt_q;

endmodule
